// File: rtl/serdes_word_aligner.sv
// -----------------------------------------------------------------------------
// serdes_word_aligner
//
// Sits behind the 10-bit bitslip deserializer. Searches for word alignment by
// comparing incoming words against a training pattern (K28.5). Each mismatch
// triggers one active-low bitslip pulse, then a settle period. Once LOCK_COUNT
// consecutive matches are seen, the aligner locks and forwards every word to
// the link layer with a one-cycle latency.
//
// Configuration macro: WORD_ALIGN_BOTH_RD_EN
//   defined   : both K28.5 polarities (RD- and RD+) count as a match.
//   undefined : only TRAIN_PATTERN matches.
//
// Ports:
//   clk            in   word clock
//   reset_n        in   asynchronous active-low reset
//   ready_i        in   deserializer ready; low forces IDLE
//   data_i         in   deserializer parallel word
//   realign_i      in   level; restarts the alignment search
//   bitslip_ctrl_n out  active-low slip pulse to the deserializer
//   data_o         out  aligned word (zero unless LOCKED)
//   data_valid_o   out  data_o qualified
//   locked_o       out  alignment achieved
//   align_err_o    out  search exhausted without lock
//   slip_count_o   out  slips issued in the current search (saturates at WIDTH)
//
// State table:
//   state  | meaning
//   IDLE   | counters cleared, waiting for ready_i
//   CHECK  | comparing data_i against the training pattern
//   SLIP   | bitslip_ctrl_n low for this single cycle
//   WAIT   | deserializer settling, data_i ignored
//   LOCKED | aligned, forwarding data_i to data_o
//   FAIL   | every slip position tried without lock, holding
// -----------------------------------------------------------------------------
module serdes_word_aligner #(
    parameter int                WIDTH         = 10,
    parameter logic [WIDTH-1:0]  TRAIN_PATTERN = 10'b0011111010,
    parameter int                LOCK_COUNT    = 8,
    parameter int                SLIP_WAIT     = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ready_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             realign_i,
    output logic             bitslip_ctrl_n,
    output logic [WIDTH-1:0] data_o,
    output logic             data_valid_o,
    output logic             locked_o,
    output logic             align_err_o,
    output logic [3:0]       slip_count_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
    localparam logic [2:0] S_SLIP   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_LOCKED = 3'd4;
    localparam logic [2:0] S_FAIL   = 3'd5;

    localparam int MW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
    localparam int WW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT + 1) : 1;

    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
    localparam logic [WW-1:0] WAIT_LOAD  = WW'(SLIP_WAIT - 1);
    localparam logic [3:0]    SLIP_MAX   = 4'(WIDTH);

    logic [2:0]       state_q,     state_d;
    logic [MW-1:0]    match_cnt_q, match_cnt_d;
    logic [WW-1:0]    wait_cnt_q,  wait_cnt_d;
    logic [3:0]       slip_cnt_q,  slip_cnt_d;
    logic             bitslip_n_q, bitslip_n_d;
    logic [WIDTH-1:0] data_q,      data_d;
    logic             valid_q,     valid_d;
    logic             locked_q,    locked_d;
    logic             err_q,       err_d;
    logic             is_match;

`ifdef WORD_ALIGN_BOTH_RD_EN
    assign is_match = (data_i == TRAIN_PATTERN) || (data_i == ~TRAIN_PATTERN);
`else
    assign is_match = (data_i == TRAIN_PATTERN);
`endif

    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        slip_cnt_d  = slip_cnt_q;
        bitslip_n_d = 1'b1;
        data_d      = '0;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        err_d       = err_q;

        if (state_q == S_IDLE) begin
            match_cnt_d = '0;
            wait_cnt_d  = '0;
            slip_cnt_d  = '0;
            locked_d    = 1'b0;
            err_d       = 1'b0;
            if (ready_i) begin
                state_d = S_CHECK;
            end
        end else if (!ready_i) begin
            state_d     = S_IDLE;
            match_cnt_d = '0;
            wait_cnt_d  = '0;
            slip_cnt_d  = '0;
            locked_d    = 1'b0;
            err_d       = 1'b0;
        end else if (realign_i) begin
            // Held realign parks the search in CHECK with everything cleared.
            state_d     = S_CHECK;
            match_cnt_d = '0;
            wait_cnt_d  = '0;
            slip_cnt_d  = '0;
            locked_d    = 1'b0;
            err_d       = 1'b0;
        end else begin
            case (state_q)
                S_CHECK: begin
                    if (is_match) begin
                        match_cnt_d = match_cnt_q + MW'(1);
                        if (match_cnt_q == MATCH_LAST) begin
                            state_d  = S_LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        match_cnt_d = '0;
                        if (slip_cnt_q == SLIP_MAX) begin
                            state_d = S_FAIL;
                            err_d   = 1'b1;
                        end else begin
                            state_d     = S_SLIP;
                            bitslip_n_d = 1'b0;
                        end
                    end
                end
                S_SLIP: begin
                    if (slip_cnt_q != SLIP_MAX) begin
                        slip_cnt_d = slip_cnt_q + 4'd1;
                    end
                    wait_cnt_d = WAIT_LOAD;
                    state_d    = S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt_q == '0) begin
                        state_d = S_CHECK;
                    end else begin
                        wait_cnt_d = wait_cnt_q - WW'(1);
                    end
                end
                S_LOCKED: begin
                    data_d   = data_i;
                    valid_d  = 1'b1;
                    locked_d = 1'b1;
                end
                S_FAIL: begin
                    err_d = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            match_cnt_q <= '0;
            wait_cnt_q  <= '0;
            slip_cnt_q  <= '0;
            bitslip_n_q <= 1'b1;
            data_q      <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            slip_cnt_q  <= slip_cnt_d;
            bitslip_n_q <= bitslip_n_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
        end
    end

    assign bitslip_ctrl_n = bitslip_n_q;
    assign data_o         = data_q;
    assign data_valid_o   = valid_q;
    assign locked_o       = locked_q;
    assign align_err_o    = err_q;
    assign slip_count_o   = slip_cnt_q;

endmodule

// File: doc/serdes_word_aligner.md
# serdes_word_aligner

- Downstream companion of the 10-bit bitslip deserializer.
- Consumes the deserializer's parallel word and `ready`, and finds word alignment against a known training pattern.
- While unaligned, it pulses the deserializer's active-low `bitslip_ctrl_n` input, one slip at a time.
- Once aligned, it forwards qualified words to the link layer.

## Interface
Parameters:
- `WIDTH`, 10, deserialized word width.
- `TRAIN_PATTERN`, 10'b0011111010, alignment word (K28.5, RD−).
- `LOCK_COUNT`, 8, consecutive matches required to declare lock (≥1).
- `SLIP_WAIT`, 4, settle cycles after each bitslip pulse before compares resume (≥1).

Ports:
- `clk`  in  1  word clock. Single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ready_i`  in  1  deserializer `ready`. Low forces the aligner idle.
- `data_i`  in  WIDTH  deserializer `data_o`.
- `realign_i`  in  1  level; restarts the alignment search.
- `bitslip_ctrl_n`  out  1  active-low slip pulse to the deserializer.
- `data_o`  out  WIDTH  aligned word.
- `data_valid_o`  out  1  `data_o` is qualified.
- `locked_o`  out  1  alignment achieved.
- `align_err_o`  out  1  search exhausted without lock.
- `slip_count_o`  out  4  slips issued in the current search.

## Operation
- Reset values: `bitslip_ctrl_n`=1; `data_o`=0; `data_valid_o`=0; `locked_o`=0; `align_err_o`=0; `slip_count_o`=0; state IDLE.
- All outputs are registered.

States:
- **IDLE**: clear all counters. Go to CHECK on a cycle with `ready_i`=1.
- **CHECK**: compare `data_i` with `TRAIN_PATTERN` each cycle.
  - Match: increment `match_cnt`. The match that makes `match_cnt`=`LOCK_COUNT` goes to LOCKED.
  - Mismatch: clear `match_cnt`. If `slip_count_o`=`WIDTH`, go to FAIL; otherwise go to SLIP.
- **SLIP**: `bitslip_ctrl_n`=0 for exactly this one cycle. Increment `slip_count_o`, then go to WAIT.
- **WAIT**: count `SLIP_WAIT` cycles, with `data_i` ignored, then go to CHECK.
- **LOCKED**: `locked_o`=1. Each cycle `data_o`←`data_i` and `data_valid_o`←1. No compares are made; payload may contain any value.
- **FAIL**: `align_err_o`=1. `data_valid_o`=0. Hold this state.

Transition priority in every non-IDLE state:
1. `ready_i`=0 → IDLE. All outputs return to reset values on the next edge.
2. `realign_i`=1 → CHECK. Clear `match_cnt`, `slip_count_o`, `locked_o`, `align_err_o`, `data_valid_o`.
3. Normal transitions listed above.

Other rules:
- `data_o` is zeroed whenever the state is not LOCKED.
- `slip_count_o` saturates at `WIDTH` and never wraps.
- `realign_i` held high keeps the block in CHECK with counters cleared; the search starts on the first cycle `realign_i` is low.
- Asserting `reset_n` mid-slip deasserts `bitslip_ctrl_n` immediately (asynchronous).

## Timing
- Let edge k be the edge where `ready_i` is first sampled high.
- With a continuously aligned pattern:
  - state = CHECK from edge k.
  - `locked_o` rises at edge k+`LOCK_COUNT`.
  - First `data_valid_o`/`data_o` at edge k+`LOCK_COUNT`+1.
- Per slip cost: 1 mismatch CHECK cycle + 1 SLIP cycle + `SLIP_WAIT` cycles = 6 cycles at defaults before compares resume.
- Data latency in LOCKED: 1 cycle, `data_i`→`data_o`.
- `bitslip_ctrl_n` low pulses are separated by at least `SLIP_WAIT`+1 high cycles.
- Failure detection: `align_err_o` rises on the edge after the first mismatch seen with `slip_count_o`=`WIDTH`.

## Configuration
- Macro: `WORD_ALIGN_BOTH_RD_EN`.
- Defined: CHECK also accepts `~TRAIN_PATTERN` (K28.5, RD+) as a match.
  - Both polarities count toward the same `match_cnt`.
  - A polarity switch mid-run does not clear the count.
- Undefined: only `TRAIN_PATTERN` matches; `~TRAIN_PATTERN` is a mismatch.

## Test plan
- **Aligned lock**: reset, then `ready_i`=1 with `data_i`=10'b0011111010 every cycle.
  - `locked_o`=1 at edge k+8; `slip_count_o`=0; `bitslip_ctrl_n` never low.
  - Then payload 10'h155 appears on `data_o` one cycle later with `data_valid_o`=1.
- **Rotated by 3**: the behavioural deserializer rotates the pattern one bit per slip pulse.
  - Exactly 3 one-cycle low pulses, spaced 6 cycles apart.
  - `locked_o`=1, `slip_count_o`=3.
- **Never matches**: `data_i`=10'h000 constant.
  - 10 slip pulses, then `align_err_o`=1 and `locked_o`=0.
  - After a 1-cycle `realign_i` pulse: `align_err_o`=0, `slip_count_o`=0, and the search restarts.
- **Ready drop**: drop `ready_i` while LOCKED → next edge: `locked_o`=0, `data_valid_o`=0, `data_o`=0, state IDLE.
  - Restore `ready_i` → relock 8 cycles later.
- **Broken run**: 7 matches, 1 mismatch, then matches. A slip is issued; no lock occurs before 8 consecutive post-WAIT matches.
- **Polarity macro**: with `WORD_ALIGN_BOTH_RD_EN` defined, alternate 10'b0011111010 and 10'b1100000101 → lock at k+8.
  - With the macro undefined, the same stimulus → slip on the first RD+ word.
